tt_ctrl_sequencer: RTL and testbench
====================================

Name: tt_ctrl_sequencer

Overview:
- On-chip sequencer for the project-select mux control pins `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena`.
- Accepts a target project address over a valid/ready handshake and drives the select-reset / select-increment pulse train with programmable pulse widths.
- Enables the selected project after a settle time.
- Tracks the current mux position so that forward moves skip the select reset and issue only the address delta in increment pulses.

Parameters:
- ADDR_W, 10, width of project address and position counter.
- PULSE_CYC, 4, clk cycles per pulse phase (high or low), >=1.
- SETTLE_CYC, 16, clk cycles between the last select edge and ctrl_ena assertion, >=1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid&&req_ready at a clk edge.
- req_addr  in  ADDR_W  target project index.
- req_ena  in  1  value ctrl_ena takes after selection completes.
- busy  out  1  ~req_ready.
- done  out  1  one-cycle pulse when sequence completes.
- cur_addr  out  ADDR_W  current mux position (valid when cur_valid).
- cur_valid  out  1  mux position known.
- ctrl_sel_rst_n  out  1  select-counter reset, active low.
- ctrl_sel_inc  out  1  select-counter increment, rising-edge counted by mux.
- ctrl_ena  out  1  enable of selected project.

Behaviour:
- All outputs registered except req_ready/busy, which decode state.
- Reset values: state=IDLE, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, done=0, cur_addr=0, cur_valid=0.
- rst wins over everything, including a simultaneous req_valid.
- rst mid-sequence aborts immediately to reset values; cur_valid=0 because the mux position is unknown.
- States: IDLE, RST_LO, RST_HI, INC_HI, INC_LO, SETTLE, DONE.
  - Each timed state lasts exactly its parameter cycles, counted by a down-counter loaded on entry.
- IDLE, on accept:
  - Latch addr and ena.
  - ctrl_ena<=0 at the same edge.
  - If cur_valid && req_addr>=cur_addr: remaining=req_addr-cur_addr; go to INC_HI, or SETTLE if remaining==0.
  - Otherwise go to RST_LO.
- RST_LO: ctrl_sel_rst_n=0 for PULSE_CYC.
- RST_HI: ctrl_sel_rst_n=1 for PULSE_CYC.
  - On exit: cur_addr=0, cur_valid=1, remaining=addr.
  - Next state INC_HI, or SETTLE if remaining==0.
- INC_HI: ctrl_sel_inc=1 for PULSE_CYC.
- INC_LO: ctrl_sel_inc=0 for PULSE_CYC.
  - On exit: cur_addr+=1, remaining-=1.
  - Next state INC_HI while remaining!=0, else SETTLE.
- SETTLE: SETTLE_CYC cycles, all ctrl pins static.
- DONE: one cycle with done=1; ctrl_ena<=latched ena at exit; then IDLE.
- Latency from the accept edge, with N = number of increments:
  - Full path: 2*PULSE_CYC + N*2*PULSE_CYC + SETTLE_CYC edges to DONE entry.
  - Incremental path: drop the 2*PULSE_CYC reset term.
  - ctrl_ena updates one edge after DONE entry.
- Requests while busy are not accepted; req_addr/req_ena are sampled only on the accept edge.
- Boundary cases:
  - req_addr=0 full path: reset only, no inc pulses.
  - req_addr==cur_addr: SETTLE only.
  - req_addr=2^ADDR_W-1 is legal; counters never wrap.
- ctrl_sel_rst_n and ctrl_sel_inc are never low/high simultaneously.

Decomposition:
- Package tt_ctrl_pkg holds:
  - state enum.
  - Reset-value constants for ctrl pins.
  - Latency helper function for benches.
- One sub-module, tt_ctrl_timer: loadable down-counter with an `expire` flag, width $clog2(max(PULSE_CYC,SETTLE_CYC))+1.

Test Plan:
- PULSE_CYC=2, SETTLE_CYC=3; reset then request addr=2 ena=1, cur_valid=0.
  - sel_rst_n low cycles 1-2 after the accept edge.
  - Two inc pulses, each high for 2 cycles.
  - done at edge 15; ctrl_ena=1 from edge 16; cur_addr=2.
- Then request addr=5 ena=1 → no sel_rst_n pulse, exactly 3 inc rising edges, ctrl_ena=0 during the sequence, done at edge 15, cur_addr=5.
- Then request addr=5 ena=0 → no pulses, done at edge 3, ctrl_ena stays 0.
- Then request addr=1 (backward) → full reset path, one inc pulse, cur_addr=1.
- Assert rst during the 2nd INC_HI of an addr=4 request → next cycle all outputs at reset values, cur_valid=0; the next addr=3 request takes the full reset path.
- Hold req_valid with rst=1 for 3 cycles → no accept, done never pulses; req_valid held through busy → exactly one accept per IDLE visit.

Source files
------------

// File: rtl/tt_ctrl_pkg.sv
// Shared types and constants for the project-select mux sequencer.
package tt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST_LO = 3'd1,
    ST_RST_HI = 3'd2,
    ST_INC_HI = 3'd3,
    ST_INC_LO = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Idle/reset levels of the mux control pins
  localparam logic SEL_RST_N_RST = 1'b1;
  localparam logic SEL_INC_RST   = 1'b0;
  localparam logic ENA_RST       = 1'b0;

  // Edges from the accept edge to DONE entry for a sequence with n increments
  function automatic int unsigned seq_latency(input bit          full_path,
                                              input int unsigned n_inc,
                                              input int unsigned pulse_cyc,
                                              input int unsigned settle_cyc);
    int unsigned lat;
    lat = n_inc * 2 * pulse_cyc + settle_cyc;
    if (full_path) lat = lat + 2 * pulse_cyc;
    return lat;
  endfunction

endpackage

// File: rtl/tt_ctrl_sequencer_if.sv
// Request handshake between a controller and the select sequencer.
interface tt_ctrl_sequencer_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;

  modport master (output req_valid, output req_addr, output req_ena, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  req_ena, output req_ready);

endinterface

// File: rtl/tt_ctrl_timer.sv
// Loadable down-counter; expire is high once the count has reached zero.
module tt_ctrl_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/tt_ctrl_sequencer.sv
// Drives the select-reset / select-increment pulse train for the project mux,
// reusing the known mux position so forward moves only issue the delta.
module tt_ctrl_sequencer
  import tt_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tt_ctrl_sequencer_if.slave   req,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 cur_valid,
  output logic                 ctrl_sel_rst_n,
  output logic                 ctrl_sel_inc,
  output logic                 ctrl_ena
);

  localparam int unsigned MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              ena_q, ena_d;
  logic              cur_valid_q, cur_valid_d;
  logic              sel_rst_n_q, sel_rst_n_d;
  logic              sel_inc_q, sel_inc_d;
  logic              ctrl_ena_q, ctrl_ena_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] delta_c;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_expire;

  tt_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign delta_c = req.req_addr - cur_addr_q;

  // Next-state, position tracking, timer reload and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cur_addr_d  = cur_addr_q;
    ena_d       = ena_q;
    cur_valid_d = cur_valid_q;
    ctrl_ena_d  = ctrl_ena_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          addr_d     = req.req_addr;
          ena_d      = req.req_ena;
          ctrl_ena_d = 1'b0;
          if (cur_valid_q && (req.req_addr >= cur_addr_q)) begin
            rem_d   = delta_c;
            state_d = (delta_c == '0) ? ST_SETTLE : ST_INC_HI;
          end else begin
            state_d = ST_RST_LO;
          end
        end
      end
      ST_RST_LO: begin
        if (tmr_expire) state_d = ST_RST_HI;
      end
      ST_RST_HI: begin
        if (tmr_expire) begin
          cur_addr_d  = '0;
          cur_valid_d = 1'b1;
          rem_d       = addr_q;
          state_d     = (addr_q == '0) ? ST_SETTLE : ST_INC_HI;
        end
      end
      ST_INC_HI: begin
        if (tmr_expire) state_d = ST_INC_LO;
      end
      ST_INC_LO: begin
        if (tmr_expire) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          rem_d      = rem_q - ADDR_W'(1);
          state_d    = (rem_q == ADDR_W'(1)) ? ST_SETTLE : ST_INC_HI;
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) state_d = ST_DONE;
      end
      ST_DONE: begin
        ctrl_ena_d = ena_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every timed state is entered from a different state, so a change reloads
    if (state_d != state_q) begin
      case (state_d)
        ST_RST_LO, ST_RST_HI, ST_INC_HI, ST_INC_LO: begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PULSE_CYC - 1);
        end
        ST_SETTLE: begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SETTLE_CYC - 1);
        end
        default: ;
      endcase
    end

    // Pins follow the state being entered so they line up with the state timing
    sel_rst_n_d = (state_d != ST_RST_LO);
    sel_inc_d   = (state_d == ST_INC_HI);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cur_addr_q  <= '0;
      ena_q       <= 1'b0;
      cur_valid_q <= 1'b0;
      sel_rst_n_q <= SEL_RST_N_RST;
      sel_inc_q   <= SEL_INC_RST;
      ctrl_ena_q  <= ENA_RST;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cur_addr_q  <= cur_addr_d;
      ena_q       <= ena_d;
      cur_valid_q <= cur_valid_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ctrl_ena_q  <= ctrl_ena_d;
      done_q      <= done_d;
    end
  end

  assign req.req_ready   = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign cur_addr        = cur_addr_q;
  assign cur_valid       = cur_valid_q;
  assign ctrl_sel_rst_n  = sel_rst_n_q;
  assign ctrl_sel_inc    = sel_inc_q;
  assign ctrl_ena        = ctrl_ena_q;

endmodule

// File: tb/tb_tt_ctrl_sequencer.sv
// Scoreboard bench for the project-select mux sequencer.
module tb_tt_ctrl_sequencer;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned PULSE_CYC  = 2;
  localparam int unsigned SETTLE_CYC = 3;

  typedef struct {
    int addr;
    int ena;
    int lat;
    int rst_lo;
    int edges;
    int inc_hi;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              busy, done, cur_valid, sel_rst_n, sel_inc, ctrl_ena;
  logic [ADDR_W-1:0] cur_addr;

  tt_ctrl_sequencer_if #(.ADDR_W(ADDR_W)) req_if ();

  tt_ctrl_sequencer #(
    .ADDR_W     (ADDR_W),
    .PULSE_CYC  (PULSE_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req_if),
    .busy           (busy),
    .done           (done),
    .cur_addr       (cur_addr),
    .cur_valid      (cur_valid),
    .ctrl_sel_rst_n (sel_rst_n),
    .ctrl_sel_inc   (sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: measures each sequence and checks it against the queued expectation
  int start_cyc = 0, rst_lo = 0, edges = 0, inc_hi = 0, accepts = 0;
  bit prev_busy = 0, prev_inc = 0, ena_seen = 0, overlap = 0, ena_pend = 0;
  int ena_exp = 0;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      start_cyc = cyc; rst_lo = 0; edges = 0; inc_hi = 0;
      ena_seen = 0; overlap = 0; accepts++;
    end
    if (busy) begin
      if (!sel_rst_n) rst_lo++;
      if (sel_inc) inc_hi++;
      if (sel_inc && !prev_inc) edges++;
      if (ctrl_ena) ena_seen = 1;
      if (!sel_rst_n && sel_inc) overlap = 1;
    end
    if (ena_pend) begin
      chk("ena_after_done", int'(ctrl_ena), ena_exp);
      ena_pend = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency",      cyc - start_cyc,  e.lat);
        chk("rst_lo_cycles", rst_lo,           e.rst_lo);
        chk("inc_edges",    edges,            e.edges);
        chk("inc_hi_cycles", inc_hi,           e.inc_hi);
        chk("cur_addr",     int'(cur_addr),   e.addr);
        chk("cur_valid",    int'(cur_valid),  1);
        chk("ena_in_seq",   int'(ena_seen),   0);
        chk("pin_overlap",  int'(overlap),    0);
        ena_pend = 1;
        ena_exp  = e.ena;
      end
    end
    prev_busy = busy;
    prev_inc  = sel_inc;
  end

  function automatic exp_t mk(int a, int e, int lat, int rl, int ed, int ih);
    exp_t x;
    x.addr = a; x.ena = e; x.lat = lat; x.rst_lo = rl; x.edges = ed; x.inc_hi = ih;
    return x;
  endfunction

  // Present one request, push its expectation, drop valid once accepted
  task automatic send(input int a, input bit e, input bit push, input exp_t x);
    int n;
    n = 0;
    while (!req_if.req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ready_timeout", 0, 1);
    req_if.req_valid = 1'b1;
    req_if.req_addr  = ADDR_W'(a);
    req_if.req_ena   = e;
    if (push) sb.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 5);
    if (!busy) chk("accept_timeout", 0, 1);
    req_if.req_valid = 1'b0;
    req_if.req_addr  = ~ADDR_W'(a);
    req_if.req_ena   = ~e;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    exp_t none;
    int   acc0, n;
    none = mk(0, 0, 0, 0, 0, 0);
    req_if.req_valid = 1'b0;
    req_if.req_addr  = '0;
    req_if.req_ena   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_sel_rst_n", int'(sel_rst_n), 1);
    chk("rst_sel_inc",   int'(sel_inc),   0);
    chk("rst_ena",       int'(ctrl_ena),  0);
    chk("rst_done",      int'(done),      0);
    chk("rst_cur_addr",  int'(cur_addr),  0);
    chk("rst_cur_valid", int'(cur_valid), 0);
    chk("rst_busy",      int'(busy),      0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", int'(req_if.req_ready), 1);

    // Full path from unknown position, two increments
    send(2, 1'b1, 1'b1, mk(2, 1, 15, 2, 2, 4)); wait_idle();
    // Forward move: delta of three increments, no select reset
    send(5, 1'b1, 1'b1, mk(5, 1, 15, 0, 3, 6)); wait_idle();
    // Same address: settle only, enable drops
    send(5, 1'b0, 1'b1, mk(5, 0, 3, 0, 0, 0));  wait_idle();
    // Backward move forces the reset path
    send(1, 1'b1, 1'b1, mk(1, 1, 11, 2, 1, 2)); wait_idle();

    // Abort during the second increment-high phase
    send(4, 1'b1, 1'b0, none);
    repeat (4) @(negedge clk);
    chk("abort_in_inc_hi", int'(sel_inc), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sel_rst_n", int'(sel_rst_n), 1);
    chk("abort_sel_inc",   int'(sel_inc),   0);
    chk("abort_ena",       int'(ctrl_ena),  0);
    chk("abort_done",      int'(done),      0);
    chk("abort_cur_valid", int'(cur_valid), 0);
    chk("abort_cur_addr",  int'(cur_addr),  0);
    chk("abort_busy",      int'(busy),      0);
    rst = 1'b0;
    @(negedge clk);
    // Position unknown after abort, so full path
    send(3, 1'b1, 1'b1, mk(3, 1, 19, 2, 3, 6)); wait_idle();

    // Valid held under reset: nothing accepted
    sb.push_back(mk(3, 1, 19, 2, 3, 6));
    sb.push_back(mk(3, 1, 3, 0, 0, 0));
    acc0 = accepts;
    rst = 1'b1;
    req_if.req_valid = 1'b1;
    req_if.req_addr  = ADDR_W'(3);
    req_if.req_ena   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_busy", int'(busy), 0);
      chk("rst_hold_done", int'(done), 0);
    end
    rst = 1'b0;
    // Valid held through busy: one accept per IDLE visit
    n = 0;
    while (accepts < acc0 + 2 && n < 100) begin @(negedge clk); n++; end
    req_if.req_valid = 1'b0;
    wait_idle();
    chk("accepts_held_valid", accepts - acc0, 2);

    // Top address, incremental from 3
    send(15, 1'b1, 1'b1, mk(15, 1, 51, 0, 12, 24)); wait_idle();
    // Address zero via reset only
    send(0, 1'b0, 1'b1, mk(0, 0, 7, 2, 0, 0));      wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
